conv2_issue_scheduler: RTL

Sequencer for the conv2 layer's shared 16-channel filter pipeline. It issues one output pixel per clock, in (filter, row, col) order, into the pipeline instead of waiting for each result before issuing the next. It tags every issue and realigns returning results with their coordinates. Results are buffered in a credit-protected FIFO and drained to the output feature-map writer over a valid/ready port.

---
 rtl/conv_pkg.sv | 55 +++++
 rtl/conv_result_fifo.sv | 63 ++++++
 rtl/conv2_issue_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the conv2 issue scheduler: layer geometry,
// scheduler state encoding and the per-pixel tag carried alongside the pipeline.
package conv_pkg;

  localparam int NUM_FILTERS = 32;
  localparam int MAP_DIM     = 14;
  localparam int IN_CH       = 16;

  localparam int F_W = 5;
  localparam int C_W = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE,
    S_FLUSH = ST_FLUSH
  } sched_state_t;

  typedef struct packed {
    logic [F_W-1:0] f;
    logic [C_W-1:0] i;
    logic [C_W-1:0] j;
  } pix_tag_t;

  typedef struct packed {
    logic     valid;
    pix_tag_t tag;
  } tag_slot_t;

  localparam int TAG_W = $bits(pix_tag_t);

  // Raster advance: j fastest, then i, then filter.
  function automatic pix_tag_t next_pix(input pix_tag_t p, input int nf, input int md);
    next_pix = p;
    if (int'(p.j) == md - 1) begin
      next_pix.j = '0;
      if (int'(p.i) == md - 1) begin
        next_pix.i = '0;
        next_pix.f = (int'(p.f) == nf - 1) ? '0 : p.f + F_W'(1);
      end else begin
        next_pix.i = p.i + C_W'(1);
      end
    end else begin
      next_pix.j = p.j + C_W'(1);
    end
  endfunction

endpackage

// File: rtl/conv_result_fifo.sv
// First-word-fall-through result FIFO with occupancy count and synchronous clear.
module conv_result_fifo #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 45,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr_q] <= push_data;
  end

  // Head forced to zero when empty so the port reads clean out of reset.
  assign head_valid = (count_q != '0);
  assign head_data  = head_valid ? mem[rd_ptr_q] : '0;
  assign count      = count_q;

endmodule

// File: rtl/conv2_issue_scheduler.sv
// Issues one output pixel per clock into the shared conv2 filter pipeline, realigns
// returning results with their coordinates and buffers them for the feature-map writer.
module conv2_issue_scheduler #(
  parameter int NUM_FILTERS = 32,
  parameter int MAP_DIM     = 14,
  parameter int PIPE_LAT    = 18,
  parameter int FIFO_DEPTH  = 32,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err_sync,
  output logic              pix_valid,
  output logic [4:0]        pix_f,
  output logic [3:0]        pix_i,
  output logic [3:0]        pix_j,
  input  logic              pipe_valid_out,
  input  logic [DATA_W-1:0] pipe_result,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [4:0]        wr_f,
  output logic [3:0]        wr_i,
  output logic [3:0]        wr_j,
  output logic [DATA_W-1:0] wr_data
);

  localparam int TAG_W   = conv_pkg::TAG_W;
  localparam int ENTRY_W = TAG_W + DATA_W;
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam int IFW     = $clog2(PIPE_LAT + 1);

  conv_pkg::sched_state_t state_q, state_d;
  conv_pkg::pix_tag_t     pix_q, pix_d;
  conv_pkg::tag_slot_t    tag_q [PIPE_LAT];
  conv_pkg::tag_slot_t    tag_d [PIPE_LAT];
  conv_pkg::tag_slot_t    tail;
  conv_pkg::pix_tag_t     head_tag;

  logic           pix_valid_q, pix_valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [IFW-1:0] in_flight_q, in_flight_d;

  logic               issue, last_pix, flush_now, ret_dec, credit_ok;
  logic               fifo_clear, fifo_push, fifo_pop, fifo_head_valid;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CW-1:0]      fifo_count, fifo_count_next;

  always_comb begin
    tag_d[0].valid = pix_valid_q;
    tag_d[0].tag   = pix_q;
    for (int unsigned k = 1; k < PIPE_LAT; k++) tag_d[k] = tag_q[k-1];
  end

  assign tail = tag_q[PIPE_LAT-1];

  always_comb begin
    state_d   = state_q;
    pix_d     = pix_q;
    issue     = pix_valid_q;
    last_pix  = (int'(pix_q.f) == NUM_FILTERS - 1) && (int'(pix_q.i) == MAP_DIM - 1) &&
                (int'(pix_q.j) == MAP_DIM - 1);
    flush_now = (state_q == conv_pkg::S_FLUSH) || ((state_q != conv_pkg::S_IDLE) && abort);

    fifo_clear      = flush_now;
    fifo_push       = pipe_valid_out && tail.valid && !flush_now;
    fifo_pop        = fifo_head_valid && wr_ready;
    fifo_count_next = flush_now ? '0 : fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    ret_dec     = pipe_valid_out && (in_flight_q != '0);
    in_flight_d = in_flight_q + IFW'(issue) - IFW'(ret_dec);

    err_d = err_q | (pipe_valid_out && !tail.valid);
    if (issue) pix_d = conv_pkg::next_pix(pix_q, NUM_FILTERS, MAP_DIM);

    // Completion looks at next-cycle occupancy so done lands the cycle after the last pop.
    unique case (state_q)
      conv_pkg::S_IDLE: begin
        if (start && !abort) begin
          state_d = conv_pkg::S_RUN;
          pix_d   = '0;
          err_d   = 1'b0;
        end
      end
      conv_pkg::S_RUN: begin
        if (abort)                state_d = conv_pkg::S_FLUSH;
        else if (issue && last_pix) state_d = conv_pkg::S_DRAIN;
      end
      conv_pkg::S_DRAIN: begin
        if (abort) state_d = conv_pkg::S_FLUSH;
        else if ((in_flight_d == '0) && (fifo_count_next == '0)) state_d = conv_pkg::S_DONE;
      end
      conv_pkg::S_DONE: begin
        state_d = abort ? conv_pkg::S_FLUSH : conv_pkg::S_IDLE;
      end
      conv_pkg::S_FLUSH: begin
        if (in_flight_d == '0) state_d = conv_pkg::S_IDLE;
      end
      default: state_d = conv_pkg::S_IDLE;
    endcase

    // Credits count everything issued and not yet popped, as of the next cycle.
    credit_ok   = (int'(in_flight_d) + int'(fifo_count_next)) < FIFO_DEPTH;
    pix_valid_d = (state_d == conv_pkg::S_RUN) && credit_ok;
    busy_d      = state_d inside {conv_pkg::S_RUN, conv_pkg::S_DRAIN, conv_pkg::S_FLUSH};
    done_d      = (state_d == conv_pkg::S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= conv_pkg::S_IDLE;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      in_flight_q <= '0;
      for (int unsigned k = 0; k < PIPE_LAT; k++) tag_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      in_flight_q <= in_flight_d;
      for (int unsigned k = 0; k < PIPE_LAT; k++) tag_q[k] <= tag_d[k];
    end
  end

  conv_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clear      (fifo_clear),
    .push       (fifo_push),
    .push_data  ({tail.tag, pipe_result}),
    .pop        (fifo_pop),
    .head_valid (fifo_head_valid),
    .head_data  (fifo_head),
    .count      (fifo_count)
  );

  assign head_tag  = conv_pkg::pix_tag_t'(fifo_head[ENTRY_W-1 -: TAG_W]);

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_sync  = err_q;
  assign pix_valid = pix_valid_q;
  assign pix_f     = pix_q.f;
  assign pix_i     = pix_q.i;
  assign pix_j     = pix_q.j;
  assign wr_valid  = fifo_head_valid;
  assign wr_f      = head_tag.f;
  assign wr_i      = head_tag.i;
  assign wr_j      = head_tag.j;
  assign wr_data   = fifo_head[DATA_W-1:0];

endmodule
